fb_plot_addr: RTL

Parametrised framebuffer plot address generator, successor to the fixed 8-bit Y / 7-bit X pixel-pair plotter. It holds CPU-written start position, extents, flips and palette. It walks a rectangle of pixel-pair locations, one per plot step, with automatic line wrap, up/down stepping per axis and multi-page framebuffers. It sits between the CPU register bus and the framebuffer DRAM controller, and emits row/column-multiplexed addresses plus a completion interrupt.

---
 rtl/fb_plot_pkg.sv | 23 ++
 rtl/fb_plot_addr_if.sv | 47 ++++
 rtl/fb_plot_axis_ctr.sv | 49 ++++
 rtl/fb_plot_addr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_plot_pkg.sv
// Shared constants and types for the framebuffer plot address generator.
package fb_plot_pkg;

    localparam logic [2:0] REG_YSTART = 3'd0;
    localparam logic [2:0] REG_XSTART = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_XEXT   = 3'd3;
    localparam logic [2:0] REG_YEXT   = 3'd4;

    localparam int CTRL_YFLIP   = 7;
    localparam int CTRL_XFLIP   = 6;
    localparam int CTRL_IRQ_DIS = 5;
    localparam int CTRL_PAL_HI  = 4;
    localparam int CTRL_PAL_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fb_plot_addr_if.sv
// CPU register bus, plot control and DRAM/pixel outputs of fb_plot_addr.
// master = CPU/video timing side, slave = the address generator.
interface fb_plot_addr_if #(
    parameter int XW = 7,
    parameter int YW = 8,
    parameter int PW = 1,
    parameter int CW = 8,
    parameter int DW = 8
);
    localparam int TOT = PW + YW + XW;
    localparam int RW  = TOT - CW;
    localparam int AW  = (RW > CW) ? RW : CW;

    logic          nCS;
    logic          nWR;
    logic [2:0]    A;
    logic [DW-1:0] DATA;
    logic          nPL;
    logic          PSTEP;
    logic          BLK;
    logic [PW-1:0] F;
    logic          COL;
    logic          PACC;

    logic [AW-1:0]  DRAM_A;
    logic           DRAM_OE;
    logic [TOT-1:0] LIN_A;
    logic           PLUSONE;
    logic           S;
    logic           XF;
    logic           YF;
    logic [4:0]     PAL;
    logic           PAL_OE;
    logic           BUSY;
    logic           PINT;

    modport master (
        output nCS, nWR, A, DATA, nPL, PSTEP, BLK, F, COL, PACC,
        input  DRAM_A, DRAM_OE, LIN_A, PLUSONE, S, XF, YF, PAL, PAL_OE, BUSY, PINT
    );

    modport slave (
        input  nCS, nWR, A, DATA, nPL, PSTEP, BLK, F, COL, PACC,
        output DRAM_A, DRAM_OE, LIN_A, PLUSONE, S, XF, YF, PAL, PAL_OE, BUSY, PINT
    );

endinterface

// File: rtl/fb_plot_axis_ctr.sv
// One plot axis: wrapping up/down position counter plus an extent
// down-counter whose zero value flags the last position on this axis.
module fb_plot_axis_ctr #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] start,
    input  logic [W-1:0] ext,
    input  logic         step,
    input  logic         dn,
    output logic [W-1:0] pos,
    output logic         term
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] cnt_q, cnt_d;

    // load has priority over stepping; position wraps naturally at W bits
    always_comb begin
        pos_d = pos_q;
        cnt_d = cnt_q;
        if (load) begin
            pos_d = start;
            cnt_d = ext;
        end else if (step) begin
            pos_d = dn ? (pos_q - ONE) : (pos_q + ONE);
            cnt_d = cnt_q - ONE;
        end
    end

    // position and extent registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= '0;
            cnt_q <= '0;
        end else begin
            pos_q <= pos_d;
            cnt_q <= cnt_d;
        end
    end

    assign pos  = pos_q;
    assign term = (cnt_q == '0);

endmodule

// File: rtl/fb_plot_addr.sv
// Framebuffer plot address generator: walks a rectangle of pixel-pair
// locations and emits linear and row/column-multiplexed DRAM addresses.
// Optional build macro FB_PLOT_IRQ_EN enables the completion interrupt.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for nPL low
// LOAD    | copy registers to shadows, load axis counters
// RUN     | rectangle in progress, qualified PSTEP advances
// DONE    | rectangle finished, raise interrupt, back to IDLE
module fb_plot_addr
    import fb_plot_pkg::*;
#(
    parameter int XW = 7,
    parameter int YW = 8,
    parameter int PW = 1,
    parameter int CW = 8,
    parameter int DW = 8
) (
    input  logic           CLK,
    input  logic           nRESET,
    fb_plot_addr_if.slave  bus
);

    localparam int TOT = PW + YW + XW;
    localparam int RW  = TOT - CW;
    localparam int AW  = (RW > CW) ? RW : CW;

    logic [DW-1:0] wdata;
    logic          wr_en;

    logic [YW-1:0] ystart_q, ystart_d;
    logic [XW:0]   xstart_q, xstart_d;
    logic [7:0]    ctrl_q,   ctrl_d;
    logic [XW-1:0] xext_q,   xext_d;
    logic [YW-1:0] yext_q,   yext_d;

    logic [XW:0]   xs_s_q,   xs_s_d;
    logic [XW-1:0] xext_s_q, xext_s_d;
    logic [PW-1:0] page_q,   page_d;
    logic          xf_q,     xf_d;
    logic          yf_q,     yf_d;
    logic [4:0]    pal_q,    pal_d;
    logic          busy_q,   busy_d;

    state_e        state_q,  state_d;

    logic          load_en;
    logic          x_step;
    logic          row_wrap;
    logic          step_ok;

    logic          x_load;
    logic [XW-1:0] x_start;
    logic [XW-1:0] x_ext;
    logic [XW-1:0] x_pos;
    logic          x_term;
    logic [YW-1:0] y_pos;
    logic          y_term;

    logic [TOT-1:0] lin_a;
    logic [AW-1:0]  row_a;
    logic [AW-1:0]  col_a;

    assign wdata   = bus.DATA;
    assign wr_en   = ~bus.nCS & ~bus.nWR;
    assign step_ok = bus.PSTEP & bus.BLK;

    // CPU register writes; these only reach the walk at the next LOAD
    always_comb begin
        ystart_d = ystart_q;
        xstart_d = xstart_q;
        ctrl_d   = ctrl_q;
        xext_d   = xext_q;
        yext_d   = yext_q;
        if (wr_en) begin
            case (bus.A)
                REG_YSTART: ystart_d = wdata[YW-1:0];
                REG_XSTART: xstart_d = wdata[XW:0];
                REG_CTRL:   ctrl_d   = wdata[7:0];
                REG_XEXT:   xext_d   = wdata[XW-1:0];
                REG_YEXT:   yext_d   = wdata[YW-1:0];
                default:    ;
            endcase
        end
    end

    // next state and per-cycle walk control; nPL low always restarts
    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        x_step   = 1'b0;
        row_wrap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.nPL) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.nPL) begin
                    state_d = ST_LOAD;
                end else if (step_ok) begin
                    if (!x_term)      x_step   = 1'b1;
                    else if (!y_term) row_wrap = 1'b1;
                    else              state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = bus.nPL ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // shadow copies taken at LOAD so CPU writes cannot disturb a walk
    always_comb begin
        xs_s_d   = xs_s_q;
        xext_s_d = xext_s_q;
        page_d   = page_q;
        xf_d     = xf_q;
        yf_d     = yf_q;
        pal_d    = pal_q;
        if (load_en) begin
            xs_s_d   = xstart_q;
            xext_s_d = xext_q;
            page_d   = bus.F;
            xf_d     = ctrl_q[CTRL_XFLIP];
            yf_d     = ctrl_q[CTRL_YFLIP];
            pal_d    = ctrl_q[CTRL_PAL_HI:CTRL_PAL_LO];
        end
    end

    // state, registers and shadows
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            ystart_q <= '0;
            xstart_q <= '0;
            ctrl_q   <= '0;
            xext_q   <= '0;
            yext_q   <= '0;
            xs_s_q   <= '0;
            xext_s_q <= '0;
            page_q   <= '0;
            xf_q     <= 1'b0;
            yf_q     <= 1'b0;
            pal_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ystart_q <= ystart_d;
            xstart_q <= xstart_d;
            ctrl_q   <= ctrl_d;
            xext_q   <= xext_d;
            yext_q   <= yext_d;
            xs_s_q   <= xs_s_d;
            xext_s_q <= xext_s_d;
            page_q   <= page_d;
            xf_q     <= xf_d;
            yf_q     <= yf_d;
            pal_q    <= pal_d;
            busy_q   <= busy_d;
        end
    end

    // X restarts from the shadow start on a line wrap, from live regs at LOAD
    assign x_load  = load_en | row_wrap;
    assign x_start = load_en ? xstart_q[XW:1] : xs_s_q[XW:1];
    assign x_ext   = load_en ? xext_q : xext_s_q;

    fb_plot_axis_ctr #(.W(XW)) u_x_ctr (
        .clk   (CLK),
        .rst_n (nRESET),
        .load  (x_load),
        .start (x_start),
        .ext   (x_ext),
        .step  (x_step),
        .dn    (xf_q),
        .pos   (x_pos),
        .term  (x_term)
    );

    fb_plot_axis_ctr #(.W(YW)) u_y_ctr (
        .clk   (CLK),
        .rst_n (nRESET),
        .load  (load_en),
        .start (ystart_q),
        .ext   (yext_q),
        .step  (row_wrap),
        .dn    (yf_q),
        .pos   (y_pos),
        .term  (y_term)
    );

    assign lin_a = {page_q, y_pos, x_pos};
    assign row_a = AW'(lin_a[TOT-1:CW]);
    assign col_a = AW'(lin_a[CW-1:0]);

    assign bus.LIN_A   = lin_a;
    assign bus.DRAM_A  = bus.COL ? col_a : row_a;
    assign bus.DRAM_OE = bus.BLK & busy_q;
    assign bus.PLUSONE = xs_s_q[0] & busy_q;
    assign bus.S       = xf_q ^ xs_s_q[0];
    assign bus.XF      = xf_q;
    assign bus.YF      = yf_q;
    assign bus.PAL     = pal_q;
    assign bus.PAL_OE  = busy_q & ~bus.BLK;
    assign bus.BUSY    = busy_q;

`ifdef FB_PLOT_IRQ_EN
    logic irq_dis_s_q, irq_dis_s_d;
    logic pint_q, pint_d;

    // interrupt flag: set on leaving DONE, cleared by ack or disable; set wins
    always_comb begin
        irq_dis_s_d = load_en ? ctrl_q[CTRL_IRQ_DIS] : irq_dis_s_q;
        pint_d      = pint_q;
        if (!bus.PACC || ctrl_q[CTRL_IRQ_DIS]) pint_d = 1'b0;
        if (state_q == ST_DONE && !irq_dis_s_q) pint_d = 1'b1;
    end

    // interrupt registers
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            irq_dis_s_q <= 1'b0;
            pint_q      <= 1'b0;
        end else begin
            irq_dis_s_q <= irq_dis_s_d;
            pint_q      <= pint_d;
        end
    end

    assign bus.PINT = pint_q;
`else
    logic unused_irq;
    assign unused_irq = ^{bus.PACC, ctrl_q[CTRL_IRQ_DIS]};
    assign bus.PINT   = 1'b0;
`endif

endmodule
